// File: rtl/stream_byte_packer.sv
// Packs an 8-bit valid/ready byte stream into BYTES-wide little-endian words.
// A word goes out when the last lane fills or when input_last flushes a partial word.
module stream_byte_packer #(
  parameter int BYTES      = 4,
  parameter int COUNT_BITS = $clog2(BYTES)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic [7:0]           input_data,
  input  logic                 input_last,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic [8*BYTES-1:0]   output_data,
  output logic [BYTES-1:0]     output_keep,
  output logic                 output_last
);

  localparam int W = 8 * BYTES;

  logic [COUNT_BITS-1:0] count_q, count_d;
  logic [W-1:0]          acc_q, acc_d;
  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          out_data_q, out_data_d;
  logic [BYTES-1:0]      out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;

  logic                  in_fire;
  logic                  out_fire;
  logic                  emit;
  logic [W-1:0]          merged;
  logic [BYTES-1:0]      keep_mask;

  // Handshakes: a beat moves on a rising edge where VALID && READY. The word
  // register is a single slot, so a byte is taken whenever that slot is empty
  // or being drained this cycle; output fields never change while VALID waits.
  assign input_ready = !out_valid_q || output_ready;
  assign in_fire     = input_valid && input_ready;
  assign out_fire    = out_valid_q && output_ready;
  assign emit        = in_fire && (input_last || (int'(count_q) == BYTES - 1));

  always_comb begin
    merged    = acc_q;
    keep_mask = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (int'(count_q) == k) merged[8*k +: 8] = input_data;
      keep_mask[k] = (k <= int'(count_q));
    end
  end

  always_comb begin
    count_d     = count_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    if (out_fire) out_valid_d = 1'b0;
    if (in_fire) begin
      if (emit) begin
        // Reloading here also covers a word drained in the same cycle.
        out_valid_d = 1'b1;
        out_data_d  = merged;
        out_keep_d  = keep_mask;
        out_last_d  = input_last;
        count_d     = '0;
        acc_d       = '0;
      end else begin
        acc_d   = merged;
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign output_valid = out_valid_q;
  assign output_data  = out_data_q;
  assign output_keep  = out_keep_q;
  assign output_last  = out_last_q;

endmodule
